// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-buffered UART: register map, status bit
// positions and the state encoding used by both the transmitter and receiver.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int STAT_TX_BUSY    = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_RX_AVAIL   = 2;
  localparam int STAT_RX_OVERRUN = 3;
  localparam int STAT_FRAME_ERR  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_fifo_trx_fifo.sv
// Synchronous FIFO with a combinational head (read-through) view of the
// registered storage; pointers carry a wrap bit to separate full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_fifo_trx.sv
// Full-duplex 8N1 UART with TX/RX FIFOs, programmable divider and sticky
// error flags on a 2-bit-address rd/wr strobe register bus.
module uart_fifo_trx
  import uart_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 7,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr_i,
  input  logic        rd_en_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_data_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o,
  output uart_state_e tx_state_o,
  output uart_state_e rx_state_o
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      div16, div_wr;
  logic [7:0]       rd_data_q, rd_data_d, rd_mux;
  logic             rd_valid_q;
  logic             ovr_q, ovr_d, ferr_q, ferr_d;

  logic             tx_push, tx_pop, tx_full, tx_empty, tx_busy;
  logic [7:0]       tx_dout;
  logic [TXCW-1:0]  tx_count;
  uart_state_e      tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             tx_q, tx_d;

  logic             rx_s1_q, rx_s2_q;
  uart_state_e      rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_brk_q, rx_brk_d;
  logic             rx_push, rx_pop, rx_full, rx_empty, rx_avail;
  logic [7:0]       rx_dout;
  logic [RXCW-1:0]  rx_count;
  logic             stat_rd, ovr_set, ferr_set;

  // Bus handshake: rd_en_i/wr_en_i are single-cycle strobes that are always
  // accepted; each rd_en_i yields exactly one rd_valid_o pulse on the next clock.
  assign stat_rd = rd_en_i && (addr_i == REG_STATUS);
  assign tx_push = wr_en_i && (addr_i == REG_DATA);
  assign rx_pop  = rd_en_i && (addr_i == REG_DATA) && !rx_empty;

  // Divider is viewed as 16 bits on the bus; widths above 16 are not addressable.
  assign div16 = 16'(div_q);

  always_comb begin
    div_wr = div16;
    if (wr_en_i && addr_i == REG_DIV_LO) div_wr[7:0]  = wr_data_i;
    if (wr_en_i && addr_i == REG_DIV_HI) div_wr[15:8] = wr_data_i;
    div_d = DIV_W'(div_wr);
  end

  assign tx_busy  = (tx_count != '0) || (tx_state_q != S_IDLE);
  assign rx_avail = (rx_count != '0);

  always_comb begin
    rd_mux = 8'h00;
    case (addr_i)
      REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_dout;
      REG_STATUS: begin
        rd_mux[STAT_TX_BUSY]    = tx_busy;
        rd_mux[STAT_TX_FULL]    = tx_full;
        rd_mux[STAT_RX_AVAIL]   = rx_avail;
        rd_mux[STAT_RX_OVERRUN] = ovr_q;
        rd_mux[STAT_FRAME_ERR]  = ferr_q;
      end
      REG_DIV_LO: rd_mux = div16[7:0];
      default:    rd_mux = div16[15:8];
    endcase
  end

  assign rd_data_d = rd_en_i ? rd_mux : rd_data_q;
  // A new error in the same cycle as a status read wins over the clear.
  assign ovr_set   = rx_push && rx_full && !rx_pop;
  assign ovr_d     = ovr_set  || (ovr_q  && !stat_rd);
  assign ferr_d    = ferr_set || (ferr_q && !stat_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= DIV_W'(DIV_RESET);
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .din_i(wr_data_i), .pop_i(tx_pop),
    .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .din_i(rx_sh_q), .pop_i(rx_pop),
    .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1; tx_sh_d = tx_dout; tx_cnt_d = div_q; tx_state_d = S_START;
      end
      S_START: if (tx_cnt_q == '0) begin
        tx_cnt_d = div_q; tx_bit_d = 3'd0; tx_state_d = S_DATA;
      end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      S_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = div_q;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        else begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
      default: if (tx_cnt_q == '0) begin
        // Chain straight into the next start bit so queued bytes leave gap-free.
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_dout; tx_cnt_d = div_q; tx_state_d = S_START;
        end else tx_state_d = S_IDLE;
      end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
    endcase
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_brk_d   = rx_brk_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      S_IDLE: if (!rx_s2_q) begin
        rx_cnt_d = div_q >> 1; rx_state_d = S_START;
      end
      S_START: if (rx_cnt_q == '0) begin
        if (rx_s2_q) rx_state_d = S_IDLE;
        else begin
          rx_cnt_d = div_q; rx_bit_d = 3'd0; rx_state_d = S_DATA;
        end
      end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
      S_DATA: if (rx_cnt_q == '0) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_cnt_d = div_q;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
      default: if (rx_brk_q) begin
        // Line held low after a bad stop bit: stay here until it idles high.
        if (rx_s2_q) begin
          rx_brk_d = 1'b0; rx_state_d = S_IDLE;
        end
      end else if (rx_cnt_q == '0) begin
        if (rx_s2_q) begin
          rx_push = 1'b1; rx_state_d = S_IDLE;
        end else begin
          ferr_set = 1'b1; rx_brk_d = 1'b1;
        end
      end else rx_cnt_d = rx_cnt_q - DIV_W'(1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign tx_o       = tx_q;
  assign irq_o      = rx_avail || !tx_busy;
  assign tx_state_o = tx_state_q;
  assign rx_state_o = rx_state_q;

endmodule

// File: tb/tb_uart_fifo_trx.sv
// Self-checking bench for uart_fifo_trx: bus reads go through an expected-value
// queue, serial TX is compared bit-by-bit against frames built here.
module tb_uart_fifo_trx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        rd_en, wr_en;
  logic [7:0]  wr_data, rd_data;
  logic        rd_valid, tx, irq, rx;
  logic        loop_en, rx_drv;
  uart_state_e tx_state, rx_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  assign rx = loop_en ? tx : rx_drv;

  uart_fifo_trx #(.DIV_W(16), .DIV_RESET(7), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .rd_en_i(rd_en), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .wr_en_i(wr_en), .wr_data_i(wr_data), .rx_i(rx),
    .tx_o(tx), .irq_o(irq), .tx_state_o(tx_state), .rx_state_o(rx_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d reads outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every rd_valid pulse consumes one expected byte
  always @(negedge clk) begin : rd_monitor
    logic [7:0] e;
    string      t;
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 32'(rd_data), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] e, input string tag);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    rd_en = 1'b0;
    check({tag, "_vld"}, 32'(rd_valid), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int bit_clks);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_tx_low(input int max_clks, input string tag);
    for (int i = 0; i < max_clks; i++) begin
      @(negedge clk);
      if (tx === 1'b0) break;
    end
    check(tag, 32'(tx), 32'd0);
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] b;

    rst = 1'b1; addr = 2'd0; rd_en = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    loop_en = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_irq", 32'(irq), 32'd1);
    bus_read(REG_STATUS, 8'h00, "rst_status");
    bus_read(REG_DIV_LO, 8'h07, "rst_div_lo");
    bus_write(REG_DIV_HI, 8'h12);
    bus_read(REG_DIV_HI, 8'h12, "div_hi_rw");
    bus_write(REG_DIV_HI, 8'h00);

    // 0x55 at DIV=7: ten 8-clock cells
    bus_write(REG_DATA, 8'h55);
    wait_tx_low(2, "t1_start_delay");
    check("t1_irq_busy", 32'(irq), 32'd0);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge clk);
      check("t1_bit", 32'(tx), 32'(frame[k/8]));
    end
    repeat (2) @(negedge clk);
    bus_read(REG_STATUS, 8'h00, "t1_status_idle");
    check("t1_irq_idle", 32'(irq), 32'd1);

    // 17 back-to-back writes while the shifter is busy with a 0xFF primer
    bus_write(REG_DATA, 8'hFF);
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      addr = REG_DATA; wr_data = 8'(i); wr_en = 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0;
    bus_read(REG_STATUS, 8'h03, "t2_status_full");
    bus_write(REG_DIV_LO, 8'h00);
    wait_tx_low(200, "t2_first_start");
    for (int f = 0; f < 16; f++) begin
      b = 8'(f + 1);
      frame = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
        if (f > 0 || k > 0) @(negedge clk);
        check($sformatf("t2_byte%0d_bit%0d", f + 1, k), 32'(tx), 32'(frame[k]));
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_dropped_idle", 32'(tx), 32'd1);
    end
    bus_read(REG_STATUS, 8'h00, "t2_status_done");

    // loopback 0xA3 at DIV=7
    bus_write(REG_DIV_LO, 8'h07);
    loop_en = 1'b1;
    bus_write(REG_DATA, 8'hA3);
    repeat (120) @(negedge clk);
    check("t3_irq_rx", 32'(irq), 32'd1);
    bus_read(REG_STATUS, 8'h04, "t3_status_avail");
    bus_read(REG_DATA, 8'hA3, "t3_data");
    bus_read(REG_STATUS, 8'h00, "t3_status_empty");
    bus_read(REG_DATA, 8'h00, "t3_empty_read");
    loop_en = 1'b0;

    // two-clock glitch at DIV=15
    bus_write(REG_DIV_LO, 8'h0F);
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("t4_rx_idle", 32'(rx_state), 32'(S_IDLE));
    bus_read(REG_STATUS, 8'h00, "t4_status_glitch");

    // 0x3C with stop bit held low
    bus_write(REG_DIV_LO, 8'h07);
    send_rx(8'h3C, 1'b0, 8);
    repeat (20) @(negedge clk);
    bus_read(REG_STATUS, 8'h10, "t5_status_ferr");
    bus_read(REG_STATUS, 8'h00, "t5_status_clear");
    bus_read(REG_DATA, 8'h00, "t5_no_byte");

    // 17 received bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_rx(8'(8'h40 + i), 1'b1, 8);
    repeat (10) @(negedge clk);
    bus_read(REG_STATUS, 8'h0C, "t6_status_ovr");
    bus_read(REG_DATA, 8'h40, "t6_first_byte");
    bus_read(REG_DATA, 8'h41, "t6_second_byte");

    // reset in the middle of a TX frame
    bus_write(REG_DIV_LO, 8'h09);
    bus_write(REG_DATA, 8'h00);
    repeat (20) @(negedge clk);
    check("t6_tx_mid", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("t6_tx_async", 32'(tx), 32'd1);
    check("t6_rd_valid_rst", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_tx_state", 32'(tx_state), 32'(S_IDLE));
    bus_read(REG_STATUS, 8'h00, "t6_status_rst");
    bus_read(REG_DIV_LO, 8'h07, "t6_div_lo_rst");
    bus_read(REG_DIV_HI, 8'h00, "t6_div_hi_rst");
    bus_read(REG_DATA, 8'h00, "t6_rx_flushed");
    repeat (20) @(negedge clk);
    check("t6_tx_quiet", 32'(tx), 32'd1);

    // final report
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
